shift_add_mult4: RTL
====================

# shift_add_mult4

Sequential 4x4 unsigned multiplier built on the team's 4-bit carry-lookahead adder (`CLA_Adder4`). It is the stage directly downstream of that adder: one `CLA_Adder4` instance is the only add path, and its `Sum`/`Cout` are consumed every iteration. A start/done handshake loads two 4-bit operands, runs a right-shift shift-and-add loop and returns an 8-bit product. Used as the next lab step after the combinational adder.

## Interface
- No parameters; widths are fixed at 4-bit operands and an 8-bit product.
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only while `busy`=0.
- `multiplicand` in 4: operand A, captured on the accepted `start` edge.
- `multiplier` in 4: operand B, captured on the accepted `start` edge.
- `busy` out 1: high while an operation is in flight.
- `done` out 1: one-cycle pulse when `product` is updated.
- `product` out 8: A*B, held until the next completion.

## Operation
- **Registers:**
  - `M[3:0]`: latched multiplicand.
  - `acc[3:0]`: upper half.
  - `Q[3:0]`: multiplier, becomes the lower half.
  - `cnt[2:0]`, plus FSM state.
- **Adder hookup:** `CLA_Adder4` with `A`=`acc`, `B`=`M`, `Cin`=1'b0. Its `Cout` and `Sum` form a 5-bit sum.
- **State IDLE:** on `start`=1, load `M`←`multiplicand`, `Q`←`multiplier`, `acc`←0, `cnt`←0, and go to RUN.
- **State RUN, one iteration per cycle:**
  - t = `Q[0]` ? {`Cout`,`Sum`} : {1'b0,`acc`}.
  - {`acc`,`Q`} ← {t,`Q`[3:1]}, i.e. a 9-bit right shift.
  - `cnt`←`cnt`+1.
- **Termination:** when the iteration just performed is the 4th (`cnt`==3 before increment):
  - `product`←{new `acc`, new `Q`};
  - `done`←1; go to IDLE.
- **Width rules:** `Cout` is never lost because it shifts into `acc[3]`. Maximum product is 15*15=225=8'hE1, so there is no overflow.
- **Handshake and boundary rules:**
  - `start` while `busy`=1 is ignored; operands are not re-sampled.
  - `start` in the cycle `done`=1 is accepted, because `busy` is already 0.
  - Operand inputs are don't-care except on the accepting edge.

## Timing
- **Reset values:** `busy`=0, `done`=0, `product`=8'h00. State is IDLE and all internal registers are 0.
- **Asynchronous reset:** takes effect immediately, including mid-operation. The in-flight result is discarded, `product` returns to 0, and no `done` is produced.
- **Accepted start:** `start` accepted at edge E0 → `busy`=1 after E0. Iterations occur at E1..E4.
- **Completion:** at E4, `product` updates, `done`=1 and `busy`=0. `done` falls at E5 unless another completion occurs.
- **Latency:** 4 cycles from the accepting edge to `done` (without `EARLY_TERM_EN`).
- **Throughput:** one operation per 5 cycles with back-to-back `start` held high.
- **Output registering:** `product` and `done` are registered. `busy` is decoded from the state register.

## Configuration
- **`EARLY_TERM_EN` undefined:** fixed 4 iterations, always 4-cycle latency.
- **`EARLY_TERM_EN` defined:** after each iteration, the unconsumed multiplier bits are checked.
  - Those bits are the low 4−(`cnt`+1) bits of the new `Q`.
  - If they are all zero, finish immediately: `product`←({new `acc`,new `Q`} >> (3−`cnt`)).
  - Latency = max(1, index of the highest set bit of `multiplier` + 1). Examples: B=0 → 1 cycle, B=1 → 1 cycle, B=4'b0100 → 3 cycles, B=8 or above → 4 cycles.
  - The product value is identical to the non-early build in all cases.

## Test plan
- **Exhaustive:** all 256 (A,B) pairs, one per operation → `product`==A*B on each `done`. 15*15 → 8'hE1; 13*11 → 8'h8F; 0*0 → 8'h00.
- **Latency:** `start` with 9*6 → `done` exactly 4 cycles after the accepting edge, `product`=8'h36, `busy` high for exactly 4 cycles. With `EARLY_TERM_EN`, 7*2 → `done` 2 cycles after, `product`=8'h0E.
- **Busy protection:** start 5*5, then assert `start` with 15*15 on cycles 1–3 of the run → `product`=8'h19, and only one `done` pulse.
- **Back-to-back:** `start` held high with operands changing to 3*4 on the `done` cycle → `done` for 8'h19 (if preceded by 5*5), then 5 cycles later `done` with 8'h0C.
- **Reset mid-operation:** pull `rst_n` low 2 cycles into 14*14 → `busy`=0, `done`=0, `product`=8'h00 immediately. After release, the next `start` with 2*3 gives 8'h06.

Source files
------------

// File: rtl/shift_add_mult4.sv
// Sequential 4x4 unsigned shift-and-add multiplier with a start/done handshake.
// Optional early termination on exhausted multiplier bits: define EARLY_TERM_EN.
module CLA_Adder4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic [3:0] p, g;
  logic [4:0] c;
  assign p = A ^ B;
  assign g = A & B;
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign Sum  = p ^ c[3:0];
  assign Cout = c[4];
endmodule

module shift_add_mult4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0] state;
  logic [3:0] m, acc, q;
  logic [2:0] cnt;
  logic [3:0] sum;
  logic       cout;
  logic [4:0] t;
  logic [7:0] nxt;
  logic       last;
  logic [7:0] res;

  CLA_Adder4 u_add (.A(acc), .B(m), .Cin(1'b0), .Sum(sum), .Cout(cout));

  always_comb begin
    t   = q[0] ? {cout, sum} : {1'b0, acc};
    nxt = {t, q[3:1]};
`ifdef EARLY_TERM_EN
    // Unconsumed multiplier bits sit in the low 4-(cnt+1) bits of the new Q.
    last = ((nxt[3:0] & (4'hF >> (cnt + 3'd1))) == 4'h0);
    res  = nxt >> (3'd3 - cnt);
`else
    last = (cnt == 3'd3);
    res  = nxt;
`endif
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m       <= '0;
      acc     <= '0;
      q       <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          m     <= multiplicand;
          q     <= multiplier;
          acc   <= '0;
          cnt   <= '0;
          state <= RUN;
        end
        default: begin
          acc <= nxt[7:4];
          q   <= nxt[3:0];
          cnt <= cnt + 3'd1;
          if (last) begin
            product <= res;
            done    <= 1'b1;
            state   <= IDLE;
          end
        end
      endcase
    end
  end
endmodule
